// File: rtl/i2c_reg_master.sv
// i2c_reg_master: I2C master running complete register-write / register-read transactions.
// Latency: (20+9n) slots for writes, (30+9n) for reads, 4*CLK_DIV clk per slot; done one cycle after STOP.
// Backpressure: start is taken only while busy=0; requests arriving during a transaction are dropped.
module i2c_reg_master #(
  parameter int CLK_DIV   = 250,
  parameter int MAX_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rw,
  input  logic [6:0]             dev_addr,
  input  logic [7:0]             reg_addr,
  input  logic [3:0]             nbytes,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   ack_err,
  output logic                   scl,
  inout  wire                    sda
);

  localparam int QW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);
  localparam logic [3:0] NMAX = 4'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_W,
    RSTART, ADDR_R, ACK_AR, RDATA, MACK, STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [QW-1:0]          qcnt_q, qcnt_d;
  logic [1:0]             phase_q, phase_d;
  logic [2:0]             bit_q, bit_d;
  logic [3:0]             byte_q, byte_d;
  logic [3:0]             n_q, n_d;
  logic                   rw_q, rw_d;
  logic [6:0]             dev_q, dev_d;
  logic [7:0]             reg_q, reg_d;
  logic [8*MAX_BYTES-1:0] wdata_q, wdata_d;
  logic [8*MAX_BYTES-1:0] rdata_q, rdata_d;
  logic [7:0]             rx_q, rx_d;
  logic                   ack_err_q, ack_err_d;
  logic                   done_q, done_d;

  logic       slot_end, sample, last_byte;
  logic [3:0] n_eff, widx;
  logic [7:0] cur_byte, wbyte;
  logic       sda_in, sda_oe, sda_o;

  assign sda_in    = sda;
  assign sda       = sda_oe ? sda_o : 1'bz;
  assign slot_end  = (phase_q == 2'd3) && (qcnt_q == QMAX);
  assign sample    = (phase_q == 2'd2) && (qcnt_q == '0);
  assign last_byte = ((byte_q + 4'd1) == n_q);
  assign widx      = n_q - byte_q - 4'd1;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

  // Effective byte count: clamp to capacity, a read always moves at least one byte
  always_comb begin
    n_eff = nbytes;
    if (nbytes > NMAX) n_eff = NMAX;
    if (rw && (nbytes == 4'd0)) n_eff = 4'd1;
  end

  // Byte currently being shifted out by the master (MSB first)
  always_comb begin
    wbyte = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (int'(widx) == i) wbyte = wdata_q[8*i +: 8];
    end
    cur_byte = 8'h00;
    case (state_q)
      ADDR_W:  cur_byte = {dev_q, 1'b0};
      REG:     cur_byte = reg_q;
      WDATA:   cur_byte = wbyte;
      ADDR_R:  cur_byte = {dev_q, 1'b1};
      default: cur_byte = 8'h00;
    endcase
  end

  // State register and datapath flops; synchronous reset abandons the bus immediately
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      qcnt_q    <= '0;
      phase_q   <= 2'd0;
      bit_q     <= 3'd0;
      byte_q    <= 4'd0;
      n_q       <= 4'd0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rx_q      <= 8'd0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      n_q       <= n_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rx_q      <= rx_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  // Next-state: advance only at slot boundaries; any NACK diverts to STOP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = START;
      START:  if (slot_end) state_d = ADDR_W;
      ADDR_W: if (slot_end && bit_q == 3'd7) state_d = ACK_A;
      ACK_A:  if (slot_end) state_d = ack_err_q ? STOP : REG;
      REG:    if (slot_end && bit_q == 3'd7) state_d = ACK_R;
      ACK_R:  if (slot_end) begin
                if (ack_err_q)          state_d = STOP;
                else if (rw_q)          state_d = RSTART;
                else if (n_q == 4'd0)   state_d = STOP;
                else                    state_d = WDATA;
              end
      WDATA:  if (slot_end && bit_q == 3'd7) state_d = ACK_W;
      ACK_W:  if (slot_end) state_d = (ack_err_q || last_byte) ? STOP : WDATA;
      RSTART: if (slot_end) state_d = ADDR_R;
      ADDR_R: if (slot_end && bit_q == 3'd7) state_d = ACK_AR;
      ACK_AR: if (slot_end) state_d = ack_err_q ? STOP : RDATA;
      RDATA:  if (slot_end && bit_q == 3'd7) state_d = MACK;
      MACK:   if (slot_end) state_d = last_byte ? STOP : RDATA;
      STOP:   if (slot_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request capture, quarter/bit/byte counters, ACK and read-data sampling
  always_comb begin
    qcnt_d    = qcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    n_d       = n_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rx_d      = rx_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      qcnt_d  = '0;
      phase_d = 2'd0;
      bit_d   = 3'd0;
      byte_d  = 4'd0;
      if (start) begin
        rw_d      = rw;
        dev_d     = dev_addr;
        reg_d     = reg_addr;
        n_d       = n_eff;
        wdata_d   = wdata;
        rdata_d   = '0;
        ack_err_d = 1'b0;
      end
    end else begin
      if (qcnt_q == QMAX) begin
        qcnt_d  = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + QW'(1);
      end
      if (sample) begin
        case (state_q)
          ACK_A, ACK_R, ACK_W, ACK_AR: if (sda_in) ack_err_d = 1'b1;
          RDATA:                       rx_d = {rx_q[6:0], sda_in};
          default: ;
        endcase
      end
      if (slot_end) begin
        case (state_q)
          ADDR_W, REG, WDATA, ADDR_R: bit_d = bit_q + 3'd1;
          RDATA: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              for (int i = 0; i < MAX_BYTES; i++) begin
                if (int'(widx) == i) rdata_d[8*i +: 8] = rx_q;
              end
            end
          end
          ACK_W, MACK: byte_d = byte_q + 4'd1;
          STOP:        done_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Bus pins: SCL/SDA waveform per state and quarter phase
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    sda_o  = 1'b1;
    case (state_q)
      IDLE: ;
      START: begin
        scl    = (phase_q != 2'd3);
        sda_oe = 1'b1;
        sda_o  = (phase_q < 2'd2);
      end
      RSTART: begin
        scl    = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_oe = 1'b1;
        sda_o  = (phase_q < 2'd2);
      end
      STOP: begin
        scl    = (phase_q != 2'd0);
        sda_oe = (phase_q != 2'd3);
        sda_o  = (phase_q == 2'd2);
      end
      ADDR_W, REG, WDATA, ADDR_R: begin
        scl    = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_oe = 1'b1;
        sda_o  = cur_byte[3'd7 - bit_q];
      end
      MACK: begin
        scl    = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_oe = !last_byte;
        sda_o  = 1'b0;
      end
      default: begin
        scl = (phase_q == 2'd1) || (phase_q == 2'd2);
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: register-file I2C slave on the bus, transaction-level reference model,
// scoreboard popped by a done-triggered monitor.
module tb_i2c_reg_master;
  localparam int CLK_DIV = 2;
  localparam int MAXB    = 2;
  localparam int SLOT    = 4 * CLK_DIV;
  localparam logic [6:0] SLV = 7'h4B;
  localparam int E_S  = 32'h1000;
  localparam int E_SR = 32'h1001;
  localparam int E_P  = 32'h2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [6:0]  dev_addr = 7'd0;
  logic [7:0]  reg_addr = 8'd0;
  logic [3:0]  nbytes = 4'd0;
  logic [15:0] wdata = 16'd0;
  logic [15:0] rdata;
  logic        busy, done, ack_err, scl;
  wire         sda_bus;
  logic        slv_low = 1'b0;

  pullup (sda_bus);
  assign sda_bus = slv_low ? 1'b0 : 1'bz;

  i2c_reg_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .nbytes(nbytes), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          cycles;
    int          loglen;
  } exp_t;

  exp_t       exp_q[$];
  int         exp_log[$];
  int         act_log[$];
  logic [7:0] ref_mem [256];
  logic [7:0] slv_mem [256];
  bit         slv_active = 0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bus byte sequence, result and duration of one transaction
  task automatic push_expected(input bit r, input logic [6:0] da, input logic [7:0] ra,
                               input logic [3:0] nb, input logic [15:0] wd);
    exp_t e;
    int n, cnt, slots, a;
    logic [7:0] b;
    n = (int'(nb) > MAXB) ? MAXB : int'(nb);
    if (r && n == 0) n = 1;
    e.rdata = 16'd0;
    e.err = 1'b0;
    cnt = 0;
    exp_log.push_back(E_S); cnt++;
    if (da != SLV) begin
      exp_log.push_back(32'h100 | int'({da, 1'b0})); cnt++;
      e.err = 1'b1;
      slots = 11;
    end else begin
      exp_log.push_back(int'({da, 1'b0})); cnt++;
      exp_log.push_back(int'(ra)); cnt++;
      if (!r) begin
        slots = 20 + 9 * n;
        for (int k = 0; k < n; k++) begin
          b = 8'((wd >> (8 * (n - 1 - k))) & 16'hFF);
          a = (int'(ra) + k) & 255;
          if (a >= 240) begin
            exp_log.push_back(32'h100 | int'(b)); cnt++;
            e.err = 1'b1;
            slots = 20 + 9 * (k + 1);
            break;
          end
          exp_log.push_back(int'(b)); cnt++;
          ref_mem[a] = b;
        end
      end else begin
        slots = 30 + 9 * n;
        exp_log.push_back(E_SR); cnt++;
        exp_log.push_back(int'({da, 1'b1})); cnt++;
        for (int k = 0; k < n; k++) begin
          b = ref_mem[(int'(ra) + k) & 255];
          exp_log.push_back(((k == n - 1) ? 32'h100 : 32'h0) | int'(b)); cnt++;
          e.rdata = e.rdata | (16'(b) << (8 * (n - 1 - k)));
        end
      end
    end
    exp_log.push_back(E_P); cnt++;
    e.cycles = slots * SLOT;
    e.loglen = cnt;
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit r, input logic [6:0] da, input logic [7:0] ra,
                       input logic [3:0] nb, input logic [15:0] wd, input bit model);
    int t = 0;
    while (busy && t < 4000) begin @(negedge clk); t++; end
    if (model) push_expected(r, da, ra, nb, wd);
    rw = r; dev_addr = da; reg_addr = ra; nbytes = nb; wdata = wd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      chk("txn_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      exp_log.delete();
    end
  endtask

  // Monitor: on every done pulse, pop the expected transaction and compare
  initial begin
    int cyc = 0, rise = 0;
    bit pb = 0;
    exp_t e;
    int x;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !pb) rise = cyc;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_err", ack_err, e.err);
          chk("rdata", rdata, e.rdata);
          chk("busy_in_done_cycle", busy, 0);
          chk("busy_to_done_clocks", cyc - rise, e.cycles);
          chk("bus_entry_count", act_log.size(), e.loglen);
          for (int i = 0; i < e.loglen; i++) begin
            x = exp_log.pop_front();
            if (i < act_log.size()) chk($sformatf("bus_entry_%0d", i), act_log[i], x);
          end
        end
        act_log.delete();
      end
      pb = busy;
    end
  end

  // Slave: register-file device at SLV, pointer auto-increments, 0xF0..0xFF read-only (NACK)
  initial begin
    bit ps = 1, pd = 1, s, d;
    bit tx = 0, got_rise = 0, rd_mode = 0, last_nack = 0, m_nack = 0, nack, want, pend = 0;
    int bitc = 0, bidx = 0, pcnt = 0;
    logic [7:0] sh = 8'd0, txb = 8'd0, ptr = 8'd0;
    forever begin
      @(negedge clk);
      s = scl;
      d = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
      if (pend) begin
        pcnt++;
        if (pcnt >= CLK_DIV) begin slv_low = 1'b1; pend = 0; end
      end
      want = 0;
      if (ps && s && pd && !d) begin
        act_log.push_back(slv_active ? E_SR : E_S);
        slv_active = 1; bitc = 0; tx = 0; got_rise = 0; bidx = 0;
        slv_low = 1'b0; pend = 0;
      end else if (ps && s && !pd && d) begin
        act_log.push_back(E_P);
        slv_active = 0; slv_low = 1'b0; pend = 0;
      end else if (slv_active && !ps && s) begin
        got_rise = 1;
        if (bitc < 8) begin
          if (!tx) sh = {sh[6:0], d};
        end else if (tx) begin
          m_nack = d;
          act_log.push_back((d ? 32'h100 : 32'h0) | int'(txb));
        end
      end else if (slv_active && ps && !s && got_rise) begin
        got_rise = 0; slv_low = 1'b0; pend = 0;
        if (bitc < 8) begin
          bitc++;
          if (bitc == 8) begin
            if (!tx) begin
              if (bidx == 0) begin
                nack = (sh[7:1] != SLV);
                rd_mode = sh[0];
              end else if (bidx == 1) begin
                ptr = sh; nack = 0;
              end else begin
                nack = (ptr >= 8'hF0);
                if (!nack) slv_mem[ptr] = sh;
                ptr = ptr + 8'd1;
              end
              bidx++;
              last_nack = nack;
              act_log.push_back((nack ? 32'h100 : 32'h0) | int'(sh));
              want = !nack;
            end
          end else begin
            want = tx && !txb[7 - bitc];
          end
        end else begin
          bitc = 0;
          if (tx) begin
            if (!m_nack) begin
              txb = slv_mem[ptr]; ptr = ptr + 8'd1;
              want = !txb[7];
            end
          end else if (rd_mode && bidx == 1 && !last_nack) begin
            tx = 1; m_nack = 0;
            txb = slv_mem[ptr]; ptr = ptr + 8'd1;
            want = !txb[7];
          end
        end
        if (want) begin pend = 1; pcnt = 0; end
      end
      ps = s; pd = d;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int t;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      ref_mem[i] = b;
      slv_mem[i] = b;
    end
    ref_mem[0] = 8'h0C;   slv_mem[0] = 8'h0C;
    ref_mem[1] = 8'h80;   slv_mem[1] = 8'h80;
    ref_mem[8'hCB] = 8'hCB; slv_mem[8'hCB] = 8'hCB;

    repeat (3) @(negedge clk);
    chk("reset_scl", scl, 1);
    chk("reset_sda", sda_bus, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ack_err", ack_err, 0);
    chk("reset_rdata", rdata, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases
    issue(0, SLV, 8'h03, 4'd2, 16'hA55A, 1); wait_idle();
    issue(1, SLV, 8'h00, 4'd2, 16'h0000, 1); wait_idle();
    issue(1, SLV, 8'hCB, 4'd1, 16'h0000, 1); wait_idle();
    issue(0, 7'h22, 8'h05, 4'd2, 16'h1234, 1); wait_idle();

    // nbytes clamp plus an ignored mid-transaction start
    issue(0, SLV, 8'h20, 4'd9, 16'hBEEF, 1);
    repeat (60) @(negedge clk);
    chk("busy_mid_txn", busy, 1);
    rw = 1'b1; dev_addr = 7'h11; reg_addr = 8'h77; nbytes = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: new start in the done cycle, readback of what was written
    issue(0, SLV, 8'h40, 4'd2, 16'hC3E1, 1);
    t = 0;
    while (!done && t < 4000) begin @(negedge clk); t++; end
    chk("b2b_done_seen", done, 1);
    issue(1, SLV, 8'h40, 4'd2, 16'h0000, 1); wait_idle();

    // Data-byte NACK, pointer-only write, zero-count read
    issue(0, SLV, 8'hEF, 4'd2, 16'h1122, 1); wait_idle();
    issue(0, SLV, 8'h50, 4'd0, 16'h0000, 1); wait_idle();
    issue(1, SLV, 8'h03, 4'd0, 16'h0000, 1); wait_idle();

    // Reset during the register byte
    issue(0, SLV, 8'h10, 4'd2, 16'h9988, 0);
    repeat (13 * SLOT + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_scl", scl, 1);
    chk("midreset_sda", sda_bus, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    reset = 1'b0;
    act_log.delete();
    slv_active = 0;
    repeat (4 * SLOT) @(negedge clk);
    issue(0, SLV, 8'h10, 4'd2, 16'h9988, 1); wait_idle();
    issue(1, SLV, 8'h10, 4'd2, 16'h0000, 1); wait_idle();

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      logic [6:0] da;
      logic [7:0] ra;
      da = ($urandom_range(0, 5) == 0) ? 7'(7'h10 + $urandom_range(0, 15)) : SLV;
      ra = ($urandom_range(0, 3) == 0) ? 8'(8'hE8 + $urandom_range(0, 15)) : 8'($urandom);
      issue(1'($urandom_range(0, 1)), da, ra, 4'($urandom_range(0, 10)), 16'($urandom), 1);
      wait_idle();
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
